imem_boot_loader: RTL

// Writes a program image into the MIPS instruction memory from a byte stream and holds the
// CPU in reset until the image is complete and verified. It is the write side of the

---
 rtl/imem_boot_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Loads a program image into the instruction memory from a byte stream and
//   keeps the CPU in reset until the whole image has arrived and its checksum
//   matches. It drives the imem write port, which the CPU never writes itself.
//
//   Stream: LEN_HI, LEN_LO (big-endian 16-bit word count N), 4*N data bytes
//   (big-endian within each word), then one checksum byte equal to the XOR of
//   all data bytes.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start              1-cycle pulse that begins a (re)load; ignored while busy
//   in_valid, in_data  byte source
//   in_ready           a byte transfers on a rising edge when in_valid && in_ready
//   imem_we            one-cycle write strobe per assembled word
//   imem_addr          word address of the write
//   imem_wdata         assembled word
//   cpu_rst_n          CPU reset, released only after a good load
//   busy, done, err    status levels
//
// Handshake: in_valid/in_ready follow strict valid/ready rules. A byte moves
// only on a rising edge with both high; the source must hold in_data stable
// while in_valid is high and not accepted. in_ready does not depend on in_valid.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // Capacity in words; 17 bits so the compare against a 16-bit length
  // can express "one more than the largest length".
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_t      state, state_nx;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  chk;
  logic [23:0] shift;

  logic        accept;
  logic [15:0] len_in;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign len_in    = {len_hi, in_data};
  assign last_word = (byte_cnt == 2'd3) && (word_cnt == len - 16'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and status outputs (status decodes the registered state)
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if ({1'b0, len_in} > MAX_WORDS) state_nx = S_ERROR;
          else if (len_in == 16'd0)       state_nx = S_CHK;
          else                            state_nx = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // The write of the final word happens during the first CHK cycle.
        if (accept && last_word) state_nx = S_CHK;
      end
      S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nx = (in_data == chk) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
        if (start) state_nx = S_LEN_HI;
      end
      S_ERROR: begin
        err = 1'b1;
        if (start) state_nx = S_LEN_HI;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, checksum, imem write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      chk        <= '0;
      shift      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      // Address advances after every write; after a full-capacity image it
      // wraps to 0 but no further write follows.
      if (imem_we) imem_addr <= imem_addr + 1'b1;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            len_hi    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            chk       <= '0;
            shift     <= '0;
            imem_addr <= '0;
          end
        end
        S_LEN_HI: if (accept) len_hi <= in_data;
        S_LEN_LO: if (accept) len <= len_in;
        S_DATA: begin
          if (accept) begin
            chk      <= chk ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], in_data};
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {shift, in_data};
              word_cnt   <= word_cnt + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
